// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encodings,
// serial line levels and a counter-width helper.
// Imported by the interface-facing top module and by the bit timer.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width for a modulus of n; never narrower than one bit so a
    // modulus of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word-transfer handshake between a local producer and the serial transmitter.
// Signals: tx_valid/tx_data from the producer, tx_ready back from the transmitter.
// Modports: master = producer side, slave = transmitter side.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Ports: clk, reset (async active-low), clear (sync, holds count at 0), bit_tick.
// bit_tick is high during the last clock of every bit period.
module bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);
    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With CLKS_PER_BIT=1 the count is pinned at 0, which is also the
    // terminal count, so every clock is a bit boundary.
    assign bit_tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB-first, optional parity, stop bit.
// Ports: clk, reset (async active-low), bus (slave handshake), tx_out, tx_busy, tx_done.
// All outputs registered; one word accepted per frame, no buffering behind tx_ready.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   bus,
    output logic               tx_out,
    output logic               tx_busy,
    output logic               tx_done
);
    localparam int            BW       = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_next;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic              ready_q, ready_d;
    logic              out_d, busy_d, done_d;
    logic              bit_tick;
    logic              timer_clear;

    assign bus.tx_ready = ready_q;

    // Holding the timer cleared while idle means it sits at 0 on the
    // acceptance edge, so the start bit gets a full bit period.
    assign timer_clear = (state_q == S_IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .bit_tick (bit_tick)
    );

    assign shift_next = shift_q >> 1;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        ready_d   = ready_q;
        out_d     = tx_out;
        busy_d    = tx_busy;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                out_d   = IDLE_LEVEL;
                if (bus.tx_valid && ready_q) begin
                    shift_d   = bus.tx_data;
                    par_d     = (^bus.tx_data) ^ PARITY_ODD;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                    out_d     = START_LEVEL;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d   = S_DATA;
                    out_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = STOP_LEVEL;
                        end
                    end else begin
                        // The register drives tx_out, so the next bit is
                        // taken from the already-shifted value.
                        shift_d   = shift_next;
                        out_d     = shift_next[0];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    out_d   = STOP_LEVEL;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    state_d = S_IDLE;
                    out_d   = IDLE_LEVEL;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                out_d   = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            ready_q   <= 1'b0;
            tx_out    <= IDLE_LEVEL;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            ready_q   <= ready_d;
            tx_out    <= out_d;
            tx_busy   <= busy_d;
            tx_done   <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx across four parameter sets.
// Ports: drives clk/reset and one handshake interface per instance.
// Expected line sequences are written out per scenario.
module tb_serial_frame_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;

    int          sel = 0;
    logic        drv_valid = 1'b0;
    logic [15:0] drv_data = '0;

    logic obs_out, obs_busy, obs_done, obs_ready;
    logic out_def, busy_def, done_def;
    logic out_evn, busy_evn, done_evn;
    logic out_odd, busy_odd, done_odd;
    logic out_fst, busy_fst, done_fst;

    logic cap_line  [0:127];
    logic cap_busy  [0:127];
    logic cap_done  [0:127];
    logic cap_ready [0:127];

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(8)) if_def ();
    serial_frame_tx_if #(.DATA_W(8)) if_evn ();
    serial_frame_tx_if #(.DATA_W(8)) if_odd ();
    serial_frame_tx_if #(.DATA_W(4)) if_fst ();

    assign if_def.tx_valid = drv_valid && (sel == 0);
    assign if_evn.tx_valid = drv_valid && (sel == 1);
    assign if_odd.tx_valid = drv_valid && (sel == 2);
    assign if_fst.tx_valid = drv_valid && (sel == 3);
    assign if_def.tx_data  = drv_data[7:0];
    assign if_evn.tx_data  = drv_data[7:0];
    assign if_odd.tx_data  = drv_data[7:0];
    assign if_fst.tx_data  = drv_data[3:0];

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_def (
        .clk(clk), .reset(reset), .bus(if_def.slave),
        .tx_out(out_def), .tx_busy(busy_def), .tx_done(done_def));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_evn (
        .clk(clk), .reset(reset), .bus(if_evn.slave),
        .tx_out(out_evn), .tx_busy(busy_evn), .tx_done(done_evn));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .bus(if_odd.slave),
        .tx_out(out_odd), .tx_busy(busy_odd), .tx_done(done_odd));
    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fst (
        .clk(clk), .reset(reset), .bus(if_fst.slave),
        .tx_out(out_fst), .tx_busy(busy_fst), .tx_done(done_fst));

    always_comb begin
        obs_out = 1'b0; obs_busy = 1'b0; obs_done = 1'b0; obs_ready = 1'b0;
        case (sel)
            0: begin obs_out = out_def; obs_busy = busy_def; obs_done = done_def; obs_ready = if_def.tx_ready; end
            1: begin obs_out = out_evn; obs_busy = busy_evn; obs_done = done_evn; obs_ready = if_evn.tx_ready; end
            2: begin obs_out = out_odd; obs_busy = busy_odd; obs_done = done_odd; obs_ready = if_odd.tx_ready; end
            3: begin obs_out = out_fst; obs_busy = busy_fst; obs_done = done_fst; obs_ready = if_fst.tx_ready; end
            default: ;
        endcase
    end

    // Presents d0 until accepted, then records n negedge samples; sample 0 is
    // the first cycle after the acceptance edge. Data switches to d1 at
    // sample 0 and valid drops at sample drop_at.
    task automatic capture(input int dut, input logic [15:0] d0, input logic [15:0] d1,
                           input int drop_at, input int n, output bit acc);
        acc = 1'b0;
        sel = dut;
        @(negedge clk);
        drv_data  = d0;
        drv_valid = 1'b1;
        for (int w = 0; w < 20 && !acc; w++) begin
            if (obs_ready === 1'b1) acc = 1'b1;
            else @(negedge clk);
        end
        if (acc) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                cap_line[i]  = obs_out;
                cap_busy[i]  = obs_busy;
                cap_done[i]  = obs_done;
                cap_ready[i] = obs_ready;
                if (i == 0) drv_data = d1;
                if (i == drop_at) drv_valid = 1'b0;
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #12;
        checks++;
        if (out_def !== 1'b1 || if_def.tx_ready !== 1'b0 || busy_def !== 1'b0 || done_def !== 1'b0) begin
            errors++;
            $display("FAIL reset_def: out=%b ready=%b busy=%b done=%b, need 1 0 0 0",
                     out_def, if_def.tx_ready, busy_def, done_def);
        end
        checks++;
        if (out_fst !== 1'b1 || if_fst.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_fast: out=%b ready=%b, need 1 0", out_fst, if_fst.tx_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (if_def.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b need 0", if_def.tx_ready);
        end
        @(negedge clk);
        checks++;
        if (if_def.tx_ready !== 1'b1 || if_evn.tx_ready !== 1'b1 || if_fst.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: def=%b evn=%b fst=%b need 1 1 1",
                     if_def.tx_ready, if_evn.tx_ready, if_fst.tx_ready);
        end
    endtask

    task automatic test_basic();
        bit acc;
        logic [15:0] frame;
        logic e;
        int nbusy, ndone, done_at;
        frame = {6'b0, 1'b1, 8'hA5, 1'b0};
        capture(0, 16'h00A5, 16'h005A, 0, 44, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL basic_accept: tx_ready never seen, need acceptance");
        end else begin
            nbusy = 0; ndone = 0; done_at = -1;
            for (int i = 0; i < 44; i++) begin
                e = (i < 40) ? frame[i/4] : 1'b1;
                checks++;
                if (cap_line[i] !== e) begin
                    errors++;
                    $display("FAIL basic_line[%0d]: got %b need %b", i, cap_line[i], e);
                end
                if (cap_busy[i] === 1'b1) nbusy++;
                if (cap_done[i] === 1'b1) begin ndone++; done_at = i; end
            end
            checks++;
            if (nbusy != 40) begin errors++; $display("FAIL basic_busy_cycles: got %0d need 40", nbusy); end
            checks++;
            if (ndone != 1 || done_at != 40) begin
                errors++; $display("FAIL basic_done: pulses=%0d at %0d, need 1 at 40", ndone, done_at);
            end
            checks++;
            if (cap_ready[0] !== 1'b0 || cap_ready[40] !== 1'b1) begin
                errors++; $display("FAIL basic_ready: s0=%b s40=%b need 0 1", cap_ready[0], cap_ready[40]);
            end
        end
    endtask

    task automatic test_parity(input int dut, input logic [7:0] d, input logic par, input string name);
        bit acc;
        logic [15:0] frame;
        logic e;
        int ndone, done_at;
        frame = {5'b0, 1'b1, par, d, 1'b0};
        capture(dut, {8'h00, d}, {8'h00, ~d}, 0, 46, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL %s_accept: tx_ready never seen, need acceptance", name);
        end else begin
            ndone = 0; done_at = -1;
            for (int i = 0; i < 46; i++) begin
                e = (i < 44) ? frame[i/4] : 1'b1;
                checks++;
                if (cap_line[i] !== e) begin
                    errors++;
                    $display("FAIL %s_line[%0d]: got %b need %b", name, i, cap_line[i], e);
                end
                if (cap_done[i] === 1'b1) begin ndone++; done_at = i; end
            end
            checks++;
            if (ndone != 1 || done_at != 44) begin
                errors++; $display("FAIL %s_done: pulses=%0d at %0d, need 1 at 44", name, ndone, done_at);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [15:0] fa, fb;
        logic e;
        int ndone, first_done, second_done;
        fa = {6'b0, 1'b1, 8'h00, 1'b0};
        fb = {6'b0, 1'b1, 8'hFF, 1'b0};
        capture(0, 16'h0000, 16'h00FF, 41, 86, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL b2b_accept: tx_ready never seen, need acceptance");
        end else begin
            ndone = 0; first_done = -1; second_done = -1;
            for (int i = 0; i < 86; i++) begin
                if (i < 40)       e = fa[i/4];
                else if (i == 40) e = 1'b1;
                else if (i < 81)  e = fb[(i-41)/4];
                else              e = 1'b1;
                checks++;
                if (cap_line[i] !== e) begin
                    errors++;
                    $display("FAIL b2b_line[%0d]: got %b need %b", i, cap_line[i], e);
                end
                if (cap_done[i] === 1'b1) begin
                    ndone++;
                    if (first_done < 0) first_done = i; else second_done = i;
                end
            end
            checks++;
            if (ndone != 2 || first_done != 40 || second_done != 81) begin
                errors++;
                $display("FAIL b2b_done: pulses=%0d at %0d,%0d need 2 at 40,81", ndone, first_done, second_done);
            end
        end
    endtask

    task automatic test_midframe_reset();
        bit acc;
        logic [15:0] frame;
        logic e;
        int ndone;
        sel = 0;
        acc = 1'b0;
        @(negedge clk);
        drv_data  = 16'h003C;
        drv_valid = 1'b1;
        for (int w = 0; w < 20 && !acc; w++) begin
            if (if_def.tx_ready === 1'b1) acc = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        drv_valid = 1'b0;
        checks++;
        if (!acc || busy_def !== 1'b1) begin
            errors++;
            $display("FAIL abort_started: acc=%b busy=%b need 1 1", acc, busy_def);
        end
        // Sample 17 lies inside data bit 3 (samples 16..19).
        repeat (17) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_def !== 1'b1 || busy_def !== 1'b0 || done_def !== 1'b0 || if_def.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: out=%b busy=%b done=%b ready=%b need 1 0 0 0",
                     out_def, busy_def, done_def, if_def.tx_ready);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_def === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL abort_no_done: pulses=%0d need 0", ndone);
        end
        frame = {6'b0, 1'b1, 8'h81, 1'b0};
        capture(0, 16'h0081, 16'h007E, 0, 42, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL resume_accept: tx_ready never seen, need acceptance");
        end else begin
            for (int i = 0; i < 40; i++) begin
                e = frame[i/4];
                checks++;
                if (cap_line[i] !== e) begin
                    errors++;
                    $display("FAIL resume_line[%0d]: got %b need %b", i, cap_line[i], e);
                end
            end
            checks++;
            if (cap_done[40] !== 1'b1) begin
                errors++; $display("FAIL resume_done: got %b need 1", cap_done[40]);
            end
        end
    endtask

    task automatic test_fast();
        bit acc;
        logic [5:0] seq;
        int ndone, nbusy;
        seq = 6'b110100;  // bit i is sample i: 0,0,1,0,1,1
        capture(3, 16'h000A, 16'h0005, 0, 9, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL fast_accept: tx_ready never seen, need acceptance");
        end else begin
            ndone = 0; nbusy = 0;
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cap_line[i] !== seq[i]) begin
                    errors++;
                    $display("FAIL fast_line[%0d]: got %b need %b", i, cap_line[i], seq[i]);
                end
            end
            for (int i = 0; i < 9; i++) begin
                if (cap_done[i] === 1'b1) ndone++;
                if (cap_busy[i] === 1'b1) nbusy++;
            end
            checks++;
            if (cap_done[6] !== 1'b1 || ndone != 1) begin
                errors++; $display("FAIL fast_done: s6=%b pulses=%0d need 1 1", cap_done[6], ndone);
            end
            checks++;
            if (nbusy != 6 || cap_line[6] !== 1'b1) begin
                errors++; $display("FAIL fast_busy: busy=%0d line6=%b need 6 1", nbusy, cap_line[6]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity(1, 8'hA5, 1'b0, "even_a5");
        test_parity(2, 8'h07, 1'b0, "odd_07");
        test_parity(2, 8'h03, 1'b1, "odd_03");
        test_back_to_back();
        test_midframe_reset();
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
